mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage beside the ALU and takes the same Rs/Rt operands from the operand mux.
- Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO feed the GRF write-data mux for MFHI/MFLO.
- Exposes busy so that upstream fetch/decode stalls any MDU instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU in cycles; must be >= 1.
- DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request strobe, sampled at the rising edge of clk.
- mdu_op  input  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
- operand1  input  32  Rs value.
- operand2  input  32  Rt value.
- busy  output  1  multiply/divide in flight.
- done  output  1  one-cycle pulse after HI/LO take a mult/div result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, internal counter=0. Any pending result is discarded. Values hold until the first clock edge after reset returns to 1.
- States:
  - IDLE: counter==0.
  - RUN: counter!=0.
  - busy = (counter != 0), driven from registered state only, never combinationally from start.
- Accept:
  - A request is accepted at an edge where reset=1, start=1, busy=0 and mdu_op is in 1..6.
  - start while busy is ignored with no effect on state, HI/LO or counter. Upstream must stall.
  - mdu_op 0 or 7 is ignored.
- MULT/MULTU accept edge E0:
  - Latch operands and the 64-bit product: signed for MULT, unsigned for MULTU.
  - counter <= MULT_CYCLES.
- DIV/DIVU accept edge E0:
  - Latch quotient and remainder.
  - counter <= DIV_CYCLES.
- Countdown: each subsequent edge decrements counter by 1.
  - Busy is high for exactly N cycles, from after E0 through edge EN.
  - At EN, where counter goes 1->0: {hi,lo} <= result, busy falls, and done=1 for exactly the one cycle after EN.
  - A new request may be accepted at the edge after EN, i.e. back-to-back with a one-cycle gap.
- Result formats:
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (operand2==0):
  - Still busy for DIV_CYCLES and done still pulses.
  - hi and lo keep their prior values.
- MTHI/MTLO:
  - Single cycle, never raise busy or done.
  - At the accept edge, hi <= operand1 (MTHI) or lo <= operand1 (MTLO). The other register is unchanged.
- hi and lo are stable during RUN and show the previous values until EN.
- Reset asserted mid-RUN: the operation is aborted, all outputs go to 0 at once, and no done pulse is produced.

Test Plan:
- MULT: operand1=0xFFFFFFFE, operand2=3, start for 1 cycle -> busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses 1 cycle.
- MULTU: 0xFFFFFFFF * 2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. DIVU 0xFFFFFFF9 / 2 -> lo=0x7FFFFFFC, hi=0x00000001 after 10 busy cycles.
- Signed division:
  - DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIV 5/0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, done pulses, hi/lo stay 0x11/0x22.
- MTHI operand1=0xDEADBEEF, then MTLO 0x12345678 on consecutive cycles -> hi=0xDEADBEEF, lo=0x12345678, busy never asserted.
- During a DIV run, issue start with MTLO 0xAAAA and with MULT -> both ignored. The final hi/lo come from the DIV only and busy lasts exactly 10 cycles.
- Drive reset=0 asynchronously (between clock edges) at cycle 3 of a MULT -> busy, done, hi, lo go to 0 immediately. After release there is no done pulse and hi/lo remain 0.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed and captured when the request is accepted. It is
// committed to HI/LO after a fixed busy window, so the busy window only
// models the latency that the pipeline observes.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_res;      // {hi, lo} waiting to be committed
  logic          r_res_wr;   // cleared for divide by zero so HI/LO keep their value
  logic          r_done;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_q_raw;
  logic [31:0] w_r_raw;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic        w_div_zero;

  // Products: a sign- or zero-extended 64-bit multiply keeps the low 64 bits exact.
  always_comb begin
    w_prod_s = {{32{operand1[31]}}, operand1} * {{32{operand2[31]}}, operand2};
    w_prod_u = {32'd0, operand1} * {32'd0, operand2};
  end

  // Division on magnitudes. The signed result is then fixed up so that it
  // truncates toward zero and the remainder takes the dividend's sign.
  // Working on magnitudes also makes 0x80000000 / -1 come out as 0x80000000
  // without relying on any signed-overflow behaviour.
  always_comb begin
    w_div_zero = (operand2 == 32'd0);
    w_a_mag    = operand1[31] ? (~operand1 + 32'd1) : operand1;
    w_b_mag    = operand2[31] ? (~operand2 + 32'd1) : operand2;
    w_dvd      = (mdu_op == OP_DIV) ? w_a_mag : operand1;
    w_dvs      = operand2;
    if (mdu_op == OP_DIV) begin
      w_dvs = w_b_mag;
    end
    if (w_div_zero) begin
      w_dvs = 32'd1;
    end
    w_q_raw = w_dvd / w_dvs;
    w_r_raw = w_dvd % w_dvs;
    w_q_s   = (operand1[31] ^ operand2[31]) ? (~w_q_raw + 32'd1) : w_q_raw;
    w_r_s   = operand1[31] ? (~w_r_raw + 32'd1) : w_r_raw;
  end

  // Control FSM: the IDLE/RUN state mirrors counter==0 / counter!=0.
  // HI/LO are written on accept (MTHI/MTLO) or on the final countdown edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_res    <= 64'd0;
      r_res_wr <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            case (mdu_op)
              OP_MULT: begin
                r_res    <= w_prod_s;
                r_res_wr <= 1'b1;
                r_cnt    <= MULT_LOAD;
                r_state  <= ST_RUN;
              end
              OP_MULTU: begin
                r_res    <= w_prod_u;
                r_res_wr <= 1'b1;
                r_cnt    <= MULT_LOAD;
                r_state  <= ST_RUN;
              end
              OP_DIV: begin
                r_res    <= {w_r_s, w_q_s};
                r_res_wr <= !w_div_zero;
                r_cnt    <= DIV_LOAD;
                r_state  <= ST_RUN;
              end
              OP_DIVU: begin
                r_res    <= {w_r_raw, w_q_raw};
                r_res_wr <= !w_div_zero;
                r_cnt    <= DIV_LOAD;
                r_state  <= ST_RUN;
              end
              OP_MTHI: r_hi <= operand1;
              OP_MTLO: r_lo <= operand1;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (r_cnt == CNT_ONE) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            if (r_res_wr) begin
              r_hi <= r_res[63:32];
              r_lo <= r_res[31:0];
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (r_cnt != '0);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: HI/LO results, busy window length, done pulse,
// ignored requests and asynchronous reset abort.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  mdu dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_op   (mdu_op),
    .operand1 (operand1),
    .operand2 (operand2),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns at the falling edge after it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    mdu_op   = op;
    operand1 = a;
    operand2 = b;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'd0;
  endtask

  // Count falling edges with busy high (bounded); ends at the first idle one.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Run one mult/div and check latency, done pulse and HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int c;
    issue(op, a, b);
    wait_idle(c);
    chk({tag, "_cycles"}, 32'(c), 32'(n));
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    @(negedge clk);
    chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    mdu_op   = 3'd0;
    operand1 = 32'd0;
    operand2 = 32'd0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Multiply and unsigned divide.
    run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("divu",  3'd4, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);

    // Signed divide: truncation toward zero, remainder follows dividend.
    run_op("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_m2", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_ovf",  3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

    // Divide by zero keeps prior HI/LO.
    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    run_op("div0", 3'd3, 32'd5, 32'd0, 10, 32'h00000011, 32'h00000022);

    // MTHI then MTLO on consecutive edges; busy never rises.
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd5; operand1 = 32'hDEADBEEF;
    @(negedge clk);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_lo_kept", lo, 32'h00000022);
    mdu_op = 3'd6; operand1 = 32'h12345678;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_done", {31'd0, done}, 32'd0);
    chk("mtlo_hi", hi, 32'hDEADBEEF);
    chk("mtlo_lo", lo, 32'h12345678);

    // Ops 0 and 7 are ignored.
    issue(3'd7, 32'h55555555, 32'd1);
    chk("op7_busy", {31'd0, busy}, 32'd0);
    chk("op7_hi", hi, 32'hDEADBEEF);
    issue(3'd0, 32'h55555555, 32'd1);
    chk("op0_lo", lo, 32'h12345678);

    // Requests during a DIV run are ignored: 100/7 -> q=14, r=2.
    issue(3'd3, 32'd100, 32'd7);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 2) begin
        start = 1'b1; mdu_op = 3'd6; operand1 = 32'h0000AAAA;
      end else if (cyc == 3) begin
        start = 1'b1; mdu_op = 3'd1; operand1 = 32'd9; operand2 = 32'd9;
      end else begin
        start = 1'b0; mdu_op = 3'd0;
      end
      if (cyc == 4) chk("ign_lo_hold", lo, 32'h12345678);
      @(negedge clk);
    end
    start = 1'b0; mdu_op = 3'd0;
    chk("ign_cycles", 32'(cyc), 32'd10);
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_hi", hi, 32'd2);
    chk("ign_lo", lo, 32'd14);
    @(negedge clk);
    chk("ign_busy_after", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the third busy cycle of a MULT.
    issue(3'd1, 32'd6, 32'd7);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("arst_no_done", {31'd0, done}, 32'd0);
    end
    chk("arst_hi_after", hi, 32'd0);
    chk("arst_lo_after", lo, 32'd0);
    chk("arst_busy_after", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
